fft4_frame_loader: RTL and testbench
====================================

FFT4_FRAME_LOADER -- requirements
Module: fft4_frame_loader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, setting the width of each signed real/imag sample.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port s_valid, input, 1 bit: an input sample is present.
REQ-005 The block SHALL have port s_ready, output, 1 bit: the block can accept a sample.
REQ-006 The block SHALL have ports s_real and s_imag, input, DATA_WIDTH bits each, signed: the input sample.
REQ-007 The block SHALL have port flush, input, 1 bit: close a partial frame with zero padding.
REQ-008 The block SHALL have ports out0_real, out0_imag through out3_real, out3_imag, output, DATA_WIDTH bits each, signed: the frame presented to fft4's in0..in3.
REQ-009 The block SHALL have port out_valid, output, 1 bit: a complete frame is presented.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the frame; tie it to 1 when feeding fft4 directly.
REQ-011 The block SHALL have port frame_count, output, 16 bits: the number of frames drained, wrapping.

Function
REQ-012 The block SHALL hold two banks (A/B) of 4 complex entries, each bank with a full flag, plus wr_bank, wr_idx[1:0] and rd_bank pointers.
REQ-013 s_ready SHALL equal !full[wr_bank], driven from registered state only, with no combinational path from any input.
REQ-014 An input beat SHALL be accepted when s_valid && s_ready; the sample is written to entry wr_idx of wr_bank, and wr_idx increments.
REQ-015 On accepting the beat with wr_idx==3, the block SHALL set full[wr_bank], toggle wr_bank and set wr_idx to 0.
REQ-016 out_valid SHALL equal full[rd_bank], and outN SHALL equal entry N of rd_bank; the outputs are stable while out_valid=1 and out_ready=0.
REQ-017 A drain SHALL occur when out_valid && out_ready: clear full[rd_bank], toggle rd_bank and increment frame_count (wrapping 0xFFFF->0).
REQ-018 Latency: out_valid SHALL rise on the cycle after the 4th sample is accepted, when that bank is rd_bank.
REQ-019 With out_ready held at 1, s_ready SHALL never deassert, giving a sustained rate of 1 sample/cycle.
REQ-020 When flush=1 and (wr_idx!=0 or a beat is accepted this cycle), the block SHALL write the beat (if any) first, zero-fill the remaining entries, set full, toggle wr_bank and set wr_idx to 0.
REQ-021 A flush with wr_idx==0 and no beat accepted SHALL have no effect.
REQ-022 A flush coinciding with an accepted 4th beat SHALL be treated as normal completion, with no extra frame.
REQ-023 A fill-completion and a drain on opposite banks in the same cycle SHALL both take effect.
REQ-024 When both banks are full, s_ready SHALL be 0, and a drain re-asserts s_ready on the next cycle.
REQ-025 No arithmetic SHALL be applied to samples; they are passed bit-exact, with no width growth.

Reset
REQ-026 rst=1 at a clock edge SHALL clear both full flags, wr_bank, rd_bank, wr_idx and frame_count, forcing out_valid=0 and s_ready=1 on the next cycle.
REQ-027 Bank data SHALL reset to 0, so outN read 0 after reset.
REQ-028 Reset mid-frame SHALL discard the partial frame, and no frame is emitted for it.
REQ-029 rst SHALL take priority over flush, s_valid and out_ready.

Structure
REQ-030 A shared package fft_pkg SHALL hold FFT_N=4, the DATA_WIDTH default and the signed complex-sample typedef {real, imag}, shared with fft4.
REQ-031 One sub-module, fft4_frame_bank, SHALL implement a single 4-entry bank with a write port, a zero-fill operation and a full flag, and be instantiated twice.
REQ-032 Control (the pointers, flush handling and frame_count) SHALL reside in fft4_frame_loader.

Verification
REQ-033 With out_ready=1, stream samples 1,2,-1,3 (imag 0) on consecutive cycles -> out_valid=1 for exactly 1 cycle, one cycle after the 4th beat, with out0..3_real=1,2,-1,3 and frame_count=1; fft4 then yields outputs 5,2+1j,-5,2-1j.
REQ-034 Hold out_ready=0 and offer 9 samples -> 8 accepted, s_ready=0 after the 8th, out_valid=1 with the first frame held; raise out_ready for 1 cycle -> s_ready=1 next cycle, and the 9th beat is accepted.
REQ-035 Accept 5 then -7 (imag 1,-1), then pulse flush -> frame {5+1j, -7-1j, 0, 0}, out_valid one cycle after the flush.
REQ-036 Accept 2 samples, assert rst for 1 cycle, then stream 4,4,4,4 -> only the frame {4,4,4,4} appears, and frame_count=1.
REQ-037 Stream 16 random samples with out_ready=1 -> s_ready is never 0, 4 frames are emitted in order bit-exact, and frame_count=4.
REQ-038 Flush coinciding with the 4th beat -> one frame only, with no zero frame following.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT definitions used by the frame loader and by fft4.
package fft_pkg;

   // Number of complex points per frame.
   localparam int FFT_N = 4;

   // Default width of each signed real/imag sample.
   localparam int DEF_DATA_WIDTH = 8;

   // Signed complex sample {real, imag} at the default width.
   typedef struct packed {
      logic signed [DEF_DATA_WIDTH-1:0] re;
      logic signed [DEF_DATA_WIDTH-1:0] im;
   } cplx_t;

endpackage

// File: rtl/fft4_frame_bank.sv
// One 4-entry complex frame bank with a single write port, a zero-fill
// of the entries from fill_from upward, and a full flag.
module fft4_frame_bank
   import fft_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               we,
   input  logic [1:0]                         widx,
   input  logic [DATA_WIDTH-1:0]              wr_real,
   input  logic [DATA_WIDTH-1:0]              wr_imag,
   input  logic                               zero_fill,
   input  logic [2:0]                         fill_from,
   input  logic                               set_full,
   input  logic                               clr_full,
   output logic                               full,
   output logic [FFT_N-1:0][DATA_WIDTH-1:0]   rd_real,
   output logic [FFT_N-1:0][DATA_WIDTH-1:0]   rd_imag
);

   // Entry storage and full flag; the write lands below fill_from, so the
   // write and the zero-fill never touch the same entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the bank storage is reset on purpose so a freshly reset
         // loader presents zeros rather than stale samples.
         rd_real <= '0;
         rd_imag <= '0;
         full    <= 1'b0;
      end else begin
         for (int i = 0; i < FFT_N; i++) begin
            if (we && (widx == 2'(i))) begin
               // NOTE: state is updated with non-blocking assignments so every
               // register samples pre-edge values, independent of block order.
               rd_real[i] <= wr_real;
               rd_imag[i] <= wr_imag;
            end else if (zero_fill && (3'(i) >= fill_from)) begin
               rd_real[i] <= '0;
               rd_imag[i] <= '0;
            end
         end
         if (set_full) begin
            full <= 1'b1;
         end else if (clr_full) begin
            full <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/fft4_frame_loader.sv
// Ping-pong loader that packs a serial complex stream into 4-point frames
// for fft4. Flush closes a partial frame with zero padding.
module fft4_frame_loader
   import fft_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic signed [DATA_WIDTH-1:0] s_real,
   input  logic signed [DATA_WIDTH-1:0] s_imag,
   input  logic                         flush,
   output logic signed [DATA_WIDTH-1:0] out0_real,
   output logic signed [DATA_WIDTH-1:0] out0_imag,
   output logic signed [DATA_WIDTH-1:0] out1_real,
   output logic signed [DATA_WIDTH-1:0] out1_imag,
   output logic signed [DATA_WIDTH-1:0] out2_real,
   output logic signed [DATA_WIDTH-1:0] out2_imag,
   output logic signed [DATA_WIDTH-1:0] out3_real,
   output logic signed [DATA_WIDTH-1:0] out3_imag,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [15:0]                  frame_count
);

   logic                              wr_bank;
   logic                              rd_bank;
   logic [1:0]                        wr_idx;
   logic [1:0]                        bank_full;
   logic [FFT_N-1:0][DATA_WIDTH-1:0]  bank_real [2];
   logic [FFT_N-1:0][DATA_WIDTH-1:0]  bank_imag [2];

   logic       accept;
   logic       last_beat;
   logic       do_flush;
   logic       close_frame;
   logic       drain;
   logic [2:0] fill_from;

   // Handshake outputs come only from registered flags.
   assign s_ready   = !bank_full[wr_bank];
   assign out_valid = bank_full[rd_bank];

   // Per-cycle decode of accept, frame completion, flush and drain.
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      accept      = 1'b0;
      last_beat   = 1'b0;
      do_flush    = 1'b0;
      close_frame = 1'b0;
      drain       = 1'b0;
      fill_from   = 3'd0;

      accept    = s_valid && s_ready;
      last_beat = accept && (wr_idx == 2'd3);
      // A flush on the 4th beat is just a normal completion.
      do_flush    = flush && ((wr_idx != 2'd0) || accept) && !last_beat;
      close_frame = last_beat || do_flush;
      drain       = out_valid && out_ready;
      // First entry left empty once this cycle's beat (if any) is written.
      fill_from   = {1'b0, wr_idx} + {2'b00, accept};
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      fft4_frame_bank #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_bank (
         .clk       (clk),
         .rst       (rst),
         .we        (accept && (wr_bank == 1'(b))),
         .widx      (wr_idx),
         .wr_real   (s_real),
         .wr_imag   (s_imag),
         .zero_fill (do_flush && (wr_bank == 1'(b))),
         .fill_from (fill_from),
         .set_full  (close_frame && (wr_bank == 1'(b))),
         .clr_full  (drain && (rd_bank == 1'(b))),
         .full      (bank_full[b]),
         .rd_real   (bank_real[b]),
         .rd_imag   (bank_imag[b])
      );
   end

   // Frame presented to fft4 is always the read bank.
   assign out0_real = bank_real[rd_bank][0];
   assign out0_imag = bank_imag[rd_bank][0];
   assign out1_real = bank_real[rd_bank][1];
   assign out1_imag = bank_imag[rd_bank][1];
   assign out2_real = bank_real[rd_bank][2];
   assign out2_imag = bank_imag[rd_bank][2];
   assign out3_real = bank_real[rd_bank][3];
   assign out3_imag = bank_imag[rd_bank][3];

   // Write/read pointers and drained-frame counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_bank     <= 1'b0;
         rd_bank     <= 1'b0;
         wr_idx      <= 2'd0;
         frame_count <= 16'd0;
      end else begin
         if (close_frame) begin
            wr_bank <= ~wr_bank;
            wr_idx  <= 2'd0;
         end else if (accept) begin
            wr_idx <= wr_idx + 2'd1;
         end
         if (drain) begin
            rd_bank     <= ~rd_bank;
            frame_count <= frame_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_fft4_frame_loader.sv
// Self-checking bench for fft4_frame_loader: a queue-based frame model is
// compared against the DUT every cycle, plus directed literal expectations.
module tb_fft4_frame_loader;

   localparam int W = 8;

   typedef struct packed {
      logic [3:0][W-1:0] re;
      logic [3:0][W-1:0] im;
   } frame_t;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                s_valid = 1'b0;
   logic                flush = 1'b0;
   logic                out_ready = 1'b0;
   logic signed [W-1:0] s_real = '0;
   logic signed [W-1:0] s_imag = '0;
   logic                s_ready;
   logic                out_valid;
   logic [15:0]         frame_count;
   logic signed [W-1:0] out0_real, out0_imag, out1_real, out1_imag;
   logic signed [W-1:0] out2_real, out2_imag, out3_real, out3_imag;
   logic [W-1:0]        ore [4];
   logic [W-1:0]        oim [4];

   int checks = 0;
   int errors = 0;

   // Reference model: full frames waiting for the consumer, and the frame
   // currently being assembled.
   frame_t       pend [$];
   logic [W-1:0] part_re [$];
   logic [W-1:0] part_im [$];
   int           fc = 0;

   fft4_frame_loader #(.DATA_WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_real      (s_real),
      .s_imag      (s_imag),
      .flush       (flush),
      .out0_real   (out0_real),
      .out0_imag   (out0_imag),
      .out1_real   (out1_real),
      .out1_imag   (out1_imag),
      .out2_real   (out2_real),
      .out2_imag   (out2_imag),
      .out3_real   (out3_real),
      .out3_imag   (out3_imag),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   assign ore[0] = out0_real;
   assign ore[1] = out1_real;
   assign ore[2] = out2_real;
   assign ore[3] = out3_real;
   assign oim[0] = out0_imag;
   assign oim[1] = out1_imag;
   assign oim[2] = out2_imag;
   assign oim[3] = out3_imag;

   function automatic logic [31:0] d(input logic [W-1:0] x);
      return {{(32-W){1'b0}}, x};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance the model across one clock edge with the given inputs.
   task automatic model_step(input logic v, input logic [W-1:0] r, input logic [W-1:0] i,
                             input logic fl, input logic ordy, input logic rs);
      frame_t f;
      logic   acc;
      logic   drn;
      if (rs) begin
         pend.delete();
         part_re.delete();
         part_im.delete();
         fc = 0;
      end else begin
         acc = v && (pend.size() < 2);
         drn = (pend.size() > 0) && ordy;
         if (drn) begin
            void'(pend.pop_front());
            fc = (fc + 1) % 65536;
         end
         if (acc) begin
            part_re.push_back(r);
            part_im.push_back(i);
         end
         if ((part_re.size() == 4) || (fl && (part_re.size() > 0))) begin
            f = '0;
            for (int k = 0; k < part_re.size(); k++) begin
               f.re[k] = part_re[k];
               f.im[k] = part_im[k];
            end
            pend.push_back(f);
            part_re.delete();
            part_im.delete();
         end
      end
   endtask

   // Compare every DUT output against the model.
   task automatic compare_all();
      check("s_ready", 32'(s_ready), 32'(pend.size() < 2));
      check("out_valid", 32'(out_valid), 32'(pend.size() > 0));
      check("frame_count", 32'(frame_count), 32'(fc));
      if (pend.size() > 0) begin
         for (int k = 0; k < 4; k++) begin
            check($sformatf("out%0d_real", k), d(ore[k]), d(pend[0].re[k]));
            check($sformatf("out%0d_imag", k), d(oim[k]), d(pend[0].im[k]));
         end
      end
   endtask

   // Drive one cycle of inputs, step the model, then compare after the edge.
   task automatic cycle(input logic v, input logic [W-1:0] r, input logic [W-1:0] i,
                        input logic fl, input logic ordy, input logic rs);
      s_valid   = v;
      s_real    = r;
      s_imag    = i;
      flush     = fl;
      out_ready = ordy;
      rst       = rs;
      model_step(v, r, i, fl, ordy, rs);
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset();
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic check_frame_lit(input string name, input logic [W-1:0] r0, i0, r1, i1, r2, i2, r3, i3);
      check({name, "_r0"}, d(ore[0]), d(r0));
      check({name, "_i0"}, d(oim[0]), d(i0));
      check({name, "_r1"}, d(ore[1]), d(r1));
      check({name, "_i1"}, d(oim[1]), d(i1));
      check({name, "_r2"}, d(ore[2]), d(r2));
      check({name, "_i2"}, d(oim[2]), d(i2));
      check({name, "_r3"}, d(ore[3]), d(r3));
      check({name, "_i3"}, d(oim[3]), d(i3));
   endtask

   initial begin
      int n_acc;
      int x0, x1, x2, x3;
      logic [W-1:0] seq [4];

      @(negedge clk);
      do_reset();
      do_reset();
      check("rst_s_ready", 32'(s_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_frame_count", 32'(frame_count), 32'd0);
      check_frame_lit("rst_data", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);

      // Basic frame 1,2,-1,3 with out_ready held high.
      seq[0] = 8'd1; seq[1] = 8'd2; seq[2] = 8'hFF; seq[3] = 8'd3;
      for (int k = 0; k < 4; k++) begin
         cycle(1'b1, seq[k], 8'd0, 1'b0, 1'b1, 1'b0);
         if (k == 2) check("basic_not_yet_valid", 32'(out_valid), 32'd0);
      end
      cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      check("basic_valid_after_4th", 32'(out_valid), 32'd0);
      check("basic_frame_count", 32'(frame_count), 32'd1);
      // Repeat so the frame is observed while valid (out_ready low).
      do_reset();
      for (int k = 0; k < 4; k++) cycle(1'b1, seq[k], 8'd0, 1'b0, 1'b0, 1'b0);
      check("basic_valid", 32'(out_valid), 32'd1);
      check_frame_lit("basic", 8'd1, 8'd0, 8'd2, 8'd0, 8'hFF, 8'd0, 8'd3, 8'd0);
      x0 = int'(out0_real); x1 = int'(out1_real); x2 = int'(out2_real); x3 = int'(out3_real);
      check("fft_X0", 32'(x0 + x1 + x2 + x3), 32'(5));
      check("fft_X1_re", 32'(x0 - x2), 32'(2));
      check("fft_X1_im", 32'(x3 - x1), 32'(1));
      check("fft_X2", 32'(x0 - x1 + x2 - x3), 32'(-5));
      check("fft_X3_im", 32'(x1 - x3), 32'(-1));
      cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      check("basic_single_cycle", 32'(out_valid), 32'd0);

      // Backpressure: offer 9 with out_ready low.
      do_reset();
      n_acc = 0;
      for (int k = 0; k < 9; k++) begin
         if (s_ready) n_acc++;
         cycle(1'b1, 8'(k + 1), 8'(k), 1'b0, 1'b0, 1'b0);
      end
      check("bp_accepted", 32'(n_acc), 32'd8);
      check("bp_s_ready_low", 32'(s_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_first_held", d(out0_real), d(8'd1));
      cycle(1'b1, 8'd9, 8'd8, 1'b0, 1'b1, 1'b0);
      check("bp_s_ready_back", 32'(s_ready), 32'd1);
      if (s_ready) n_acc++;
      cycle(1'b1, 8'd9, 8'd8, 1'b0, 1'b0, 1'b0);
      check("bp_ninth_accepted", 32'(n_acc), 32'd9);
      check("bp_second_frame", d(out0_real), d(8'd5));

      // Flush a 2-sample partial frame.
      do_reset();
      cycle(1'b1, 8'd5, 8'd1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'hF9, 8'hFF, 1'b0, 1'b0, 1'b0);
      check("flush_not_valid_yet", 32'(out_valid), 32'd0);
      cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      check("flush_valid", 32'(out_valid), 32'd1);
      check_frame_lit("flush", 8'd5, 8'd1, 8'hF9, 8'hFF, 8'd0, 8'd0, 8'd0, 8'd0);
      cycle(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
      check("flush_idle_no_effect", 32'(frame_count), 32'd1);

      // Reset mid-frame discards the partial frame.
      do_reset();
      cycle(1'b1, 8'd7, 8'd7, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 8'd7, 8'd7, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 8'd7, 8'd7, 1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 4; k++) cycle(1'b1, 8'd4, 8'd0, 1'b0, 1'b0, 1'b0);
      check_frame_lit("rstmid", 8'd4, 8'd0, 8'd4, 8'd0, 8'd4, 8'd0, 8'd4, 8'd0);
      cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      check("rstmid_frame_count", 32'(frame_count), 32'd1);

      // Flush coinciding with the 4th beat.
      do_reset();
      for (int k = 0; k < 4; k++) cycle(1'b1, 8'(k + 10), 8'd0, (k == 3), 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      check("flush4_one_frame", 32'(frame_count), 32'd1);
      check("flush4_no_extra", 32'(out_valid), 32'd0);

      // 16 random samples at full rate.
      do_reset();
      for (int k = 0; k < 16; k++) begin
         check("stream_s_ready", 32'(s_ready), 32'd1);
         cycle(1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b1, 1'b0);
      end
      cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      check("stream_frame_count", 32'(frame_count), 32'd4);

      // Long randomized mix of valid, ready, flush and occasional reset.
      for (int n = 0; n < 3000; n++) begin
         cycle(($urandom % 4) != 0, 8'($urandom), 8'($urandom),
               ($urandom % 8) == 0, ($urandom % 3) != 0, ($urandom % 250) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
